signal_scheduler: RTL and testbench

Intersection phase controller that sequences the four road sensors and their signal heads. Per phase:
- Picks the next road to serve (round-robin with low-traffic skip and an anti-starvation limit).
- Drives next_road to that road so the matching sensor samples its count.
- Holds green for a time scaled by that road's 8-bit vehicle average, then runs yellow and all-red clearance.

---
 rtl/signal_scheduler_if.sv | 34 +++
 rtl/signal_scheduler.sv | 152 +++++++++++++++
 tb/tb_signal_scheduler.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/signal_scheduler_if.sv
// Signal bundle between the phase controller and the intersection (sensors, signal heads, timebase).
// Carries the emergency pre-emption pair only when EMERGENCY_PREEMPT_EN is defined.
interface signal_scheduler_if;
   logic       tick;
   logic [7:0] avg_north;
   logic [7:0] avg_east;
   logic [7:0] avg_south;
   logic [7:0] avg_west;
`ifdef EMERGENCY_PREEMPT_EN
   logic       emergency_req;
   logic [1:0] emergency_road;
`endif
   logic [1:0] next_road;
   logic [3:0] green;
   logic [3:0] yellow;
   logic       all_red;
   logic [1:0] phase;

   modport master (
      output tick, avg_north, avg_east, avg_south, avg_west,
`ifdef EMERGENCY_PREEMPT_EN
      output emergency_req, emergency_road,
`endif
      input  next_road, green, yellow, all_red, phase
   );

   modport slave (
      input  tick, avg_north, avg_east, avg_south, avg_west,
`ifdef EMERGENCY_PREEMPT_EN
      input  emergency_req, emergency_road,
`endif
      output next_road, green, yellow, all_red, phase
   );
endinterface

// File: rtl/signal_scheduler.sv
// Four-road intersection phase controller: round-robin road selection with low-traffic skip,
// traffic-scaled green, yellow and all-red clearance. Optional pre-emption via EMERGENCY_PREEMPT_EN.
module signal_scheduler #(
   parameter int unsigned MIN_GREEN    = 10,
   parameter int unsigned MAX_GREEN    = 60,
   parameter int unsigned GREEN_SHIFT  = 2,
   parameter int unsigned YELLOW_TIME  = 3,
   parameter int unsigned ALL_RED_TIME = 2,
   parameter int unsigned SKIP_THRESH  = 2,
   parameter int unsigned MAX_SKIP     = 3
) (
   input logic              clk,
   input logic              reset,
   signal_scheduler_if.slave bus
);
   localparam int unsigned TW = 8;
   localparam int unsigned SW = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);

   typedef enum logic [1:0] {
      S_ALL_RED = 2'd0,
      S_GREEN   = 2'd1,
      S_YELLOW  = 2'd2
   } state_t;

   state_t          r_state, w_state_nx;
   logic [TW-1:0]   r_timer, w_timer_nx;
   logic [1:0]      r_road, w_road_nx;
   logic [SW-1:0]   r_skip [4];
   logic [SW-1:0]   w_skip_nx [4];
   logic [SW-1:0]   w_sel_skip [4];
   logic [3:0]      r_green, r_yellow, w_green_nx, w_yellow_nx;
   logic            r_all_red;
   logic [7:0]      w_avg [4];
   logic [1:0]      w_sel_road, w_cand;
   logic            w_found;
   logic [8:0]      w_gsum;
   logic            w_expire;

   always_comb begin
      w_avg[0] = bus.avg_north;
      w_avg[1] = bus.avg_east;
      w_avg[2] = bus.avg_south;
      w_avg[3] = bus.avg_west;
   end

   assign w_expire = bus.tick && (r_timer == TW'(1));

   // Scan the three other roads in order; unqualified roads passed over accumulate a skip.
   always_comb begin
      w_sel_skip = r_skip;
      w_sel_road = r_road + 2'd1;
      w_found    = 1'b0;
      w_cand     = '0;
      for (int unsigned k = 1; k < 4; k++) begin
         w_cand = r_road + 2'(k);
         if (!w_found) begin
            if ((w_avg[w_cand] >= 8'(SKIP_THRESH)) || (r_skip[w_cand] == SW'(MAX_SKIP))) begin
               w_found    = 1'b1;
               w_sel_road = w_cand;
            end else if (r_skip[w_cand] != SW'(MAX_SKIP)) begin
               w_sel_skip[w_cand] = r_skip[w_cand] + SW'(1);
            end
         end
      end
      w_sel_skip[w_sel_road] = '0;
   end

   always_comb begin
      w_state_nx = r_state;
      w_timer_nx = r_timer;
      w_road_nx  = r_road;
      w_skip_nx  = r_skip;
      w_gsum     = '0;
      case (r_state)
         S_ALL_RED: begin
            if (w_expire) begin
               w_state_nx = S_GREEN;
               w_road_nx  = w_sel_road;
               w_skip_nx  = w_sel_skip;
`ifdef EMERGENCY_PREEMPT_EN
               if (bus.emergency_req) begin
                  w_road_nx = bus.emergency_road;
                  w_skip_nx = r_skip;
               end
`endif
               w_gsum     = 9'(MIN_GREEN) + 9'(w_avg[w_road_nx] >> GREEN_SHIFT);
               w_timer_nx = (w_gsum > 9'(MAX_GREEN)) ? TW'(MAX_GREEN) : w_gsum[TW-1:0];
            end else if (bus.tick) begin
               w_timer_nx = r_timer - TW'(1);
            end
         end
         S_GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
            // Another road's emergency cuts this green short; our own emergency pins the timer.
            if (bus.emergency_req && (bus.emergency_road != r_road)) begin
               w_state_nx = S_YELLOW;
               w_timer_nx = TW'(YELLOW_TIME);
            end else if (bus.emergency_req) begin
               w_timer_nx = TW'(MIN_GREEN);
            end else
`endif
            if (w_expire) begin
               w_state_nx = S_YELLOW;
               w_timer_nx = TW'(YELLOW_TIME);
            end else if (bus.tick) begin
               w_timer_nx = r_timer - TW'(1);
            end
         end
         S_YELLOW: begin
            if (w_expire) begin
               w_state_nx = S_ALL_RED;
               w_timer_nx = TW'(ALL_RED_TIME);
            end else if (bus.tick) begin
               w_timer_nx = r_timer - TW'(1);
            end
         end
         default: begin
            w_state_nx = S_ALL_RED;
            w_timer_nx = TW'(ALL_RED_TIME);
         end
      endcase
      w_green_nx  = (w_state_nx == S_GREEN)  ? (4'b0001 << w_road_nx) : 4'b0000;
      w_yellow_nx = (w_state_nx == S_YELLOW) ? (4'b0001 << w_road_nx) : 4'b0000;
   end

   // Reset parks on road 3 so the first selection lands on road 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_ALL_RED;
         r_timer   <= TW'(ALL_RED_TIME);
         r_road    <= 2'd3;
         for (int i = 0; i < 4; i++) r_skip[i] <= '0;
         r_green   <= '0;
         r_yellow  <= '0;
         r_all_red <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_timer   <= w_timer_nx;
         r_road    <= w_road_nx;
         r_skip    <= w_skip_nx;
         r_green   <= w_green_nx;
         r_yellow  <= w_yellow_nx;
         r_all_red <= (w_state_nx == S_ALL_RED);
      end
   end

   assign bus.next_road = r_road;
   assign bus.green     = r_green;
   assign bus.yellow    = r_yellow;
   assign bus.all_red   = r_all_red;
   assign bus.phase     = r_state;
endmodule

// File: tb/tb_signal_scheduler.sv
// Bench for signal_scheduler: directed scenarios plus randomized traffic, checked every clock
// against a tick-level phase model and a log of served roads / green lengths.
module tb_signal_scheduler;
   localparam int MIN_G = 10, MAX_G = 60, G_SH = 2, Y_T = 3, AR_T = 2, SK_TH = 2, MAX_SK = 3;

   logic clk = 1'b0;
   logic reset;
   signal_scheduler_if bus();

   signal_scheduler #(
      .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .GREEN_SHIFT(G_SH), .YELLOW_TIME(Y_T),
      .ALL_RED_TIME(AR_T), .SKIP_THRESH(SK_TH), .MAX_SKIP(MAX_SK)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int avg [4];
   int m_phase, m_timer, m_road;
   int m_skip [4];
   int q_road [$];
   int q_len [$];
   int g_cnt;
   int exp_starve [11] = '{0, 2, 3, 0, 2, 3, 0, 2, 3, 0, 1};
   int exp_rr [5] = '{0, 1, 2, 3, 0};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive_avg();
      bus.avg_north = 8'(avg[0]);
      bus.avg_east  = 8'(avg[1]);
      bus.avg_south = 8'(avg[2]);
      bus.avg_west  = 8'(avg[3]);
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_timer = AR_T;
      m_road  = 3;
      for (int i = 0; i < 4; i++) m_skip[i] = 0;
   endtask

   // One tick of the phase model: phases are ALL_RED(0) -> GREEN(1) -> YELLOW(2), each N ticks long.
   task automatic model_tick();
      int chosen, c, g;
      if (m_timer > 1) begin
         m_timer--;
      end else if (m_phase == 0) begin
         chosen = -1;
         for (int k = 1; k < 4; k++) begin
            c = (m_road + k) % 4;
            if (chosen < 0) begin
               if (avg[c] >= SK_TH || m_skip[c] == MAX_SK) chosen = c;
               else if (m_skip[c] < MAX_SK) m_skip[c]++;
            end
         end
         if (chosen < 0) chosen = (m_road + 1) % 4;
         m_skip[chosen] = 0;
         m_road  = chosen;
         g       = MIN_G + (avg[chosen] >> G_SH);
         m_timer = (g > MAX_G) ? MAX_G : g;
         m_phase = 1;
      end else if (m_phase == 1) begin
         m_phase = 2;
         m_timer = Y_T;
      end else begin
         m_phase = 0;
         m_timer = AR_T;
      end
   endtask

   task automatic check_outputs();
      logic [12:0] o, e;
      logic [3:0]  eg, ey;
      eg = (m_phase == 1) ? 4'(1 << m_road) : 4'b0000;
      ey = (m_phase == 2) ? 4'(1 << m_road) : 4'b0000;
      o  = {bus.next_road, bus.green, bus.yellow, bus.all_red, bus.phase};
      e  = {2'(m_road), eg, ey, 1'(m_phase == 0), 2'(m_phase)};
      check_eq("outs", 32'(o), 32'(e));
      check_eq("one_head_lit", 32'($countones(bus.green | bus.yellow) <= 1), 32'd1);
      check_eq("allred_iff_phase0", 32'(bus.all_red == (bus.phase == 2'd0)), 32'd1);
   endtask

   function automatic int obs_road(input int i);
      return (i < q_road.size()) ? q_road[i] : -1;
   endfunction

   function automatic int obs_len(input int i);
      return (i < q_len.size()) ? q_len[i] : -1;
   endfunction

   // Called at a negedge; returns at a negedge after the tick has been consumed.
   task automatic apply_tick();
      logic was_green;
      int   idle;
      idle = int'($urandom_range(0, 2));
      repeat (idle) begin
         @(negedge clk);
         check_outputs();
      end
      was_green = (bus.green != 4'b0000);
      bus.tick = 1'b1;
      @(negedge clk);
      bus.tick = 1'b0;
      model_tick();
      check_outputs();
      if (was_green) begin
         g_cnt++;
         if (bus.green == 4'b0000) begin
            q_len.push_back(g_cnt);
            g_cnt = 0;
         end
      end else if (bus.green != 4'b0000) begin
         q_road.push_back(int'(bus.next_road));
      end
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) apply_tick();
   endtask

   // Reset asserted between clock edges must clear the heads without waiting for a clock.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #1 reset = 1'b0;
      model_reset();
      #1 check_outputs();
      check_eq(tag, 32'({bus.green, bus.yellow, bus.all_red}), 32'(9'b0_0000_0001));
      @(negedge clk);
      reset = 1'b1;
      check_outputs();
      q_road.delete();
      q_len.delete();
      g_cnt = 0;
   endtask

   initial begin
      reset    = 1'b0;
      bus.tick = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
      bus.emergency_req  = 1'b0;
      bus.emergency_road = 2'd0;
`endif
      avg = '{20, 20, 20, 20};
      drive_avg();
      model_reset();
      g_cnt = 0;

      do_reset("rst_init");
      run_ticks(45);
      check_eq("basic_road0", 32'(obs_road(0)), 32'd0);
      check_eq("basic_len0", 32'(obs_len(0)), 32'd15);
      check_eq("basic_road1", 32'(obs_road(1)), 32'd1);

      avg = '{255, 20, 20, 20};
      drive_avg();
      do_reset("rst_sat");
      run_ticks(70);
      check_eq("sat_clamp", 32'(obs_len(0)), 32'd60);

      avg[0] = 200;
      drive_avg();
      do_reset("rst_sat_exact");
      run_ticks(70);
      check_eq("sat_exact", 32'(obs_len(0)), 32'd60);

      avg[0] = 196;
      drive_avg();
      do_reset("rst_below_sat");
      run_ticks(70);
      check_eq("below_sat", 32'(obs_len(0)), 32'd59);

      avg = '{20, 0, 20, 20};
      drive_avg();
      do_reset("rst_starve");
      run_ticks(225);
      for (int i = 0; i < 11; i++) check_eq("starve_order", 32'(obs_road(i)), 32'(exp_starve[i]));
      check_eq("starve_forced_len", 32'(obs_len(10)), 32'd10);

      avg = '{0, 0, 0, 0};
      drive_avg();
      do_reset("rst_rr");
      run_ticks(80);
      for (int i = 0; i < 5; i++) begin
         check_eq("rr_order", 32'(obs_road(i)), 32'(exp_rr[i]));
         check_eq("rr_len", 32'(obs_len(i)), 32'd10);
      end

      avg = '{20, 20, 20, 20};
      drive_avg();
      do_reset("rst_pre_async");
      run_ticks(8);
      check_eq("mid_green", 32'(bus.green), 32'(4'b0001));
      do_reset("async_rst_mid_green");
      run_ticks(30);
      check_eq("restart_road0", 32'(obs_road(0)), 32'd0);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 0) avg[$urandom_range(0, 3)] = int'($urandom_range(0, 3));
            else avg[$urandom_range(0, 3)] = int'($urandom_range(0, 255));
            drive_avg();
         end
         apply_tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
